// File: rtl/rc_lowpass_filter_serial.sv
// Single-pole RC low-pass: y += alpha*(x - y) once per audio_clk_en, using one
// shift-add multiplier stepped over 16 clocks per sample.
module rc_lowpass_filter_serial #(
  parameter int unsigned CLOCK_RATE   = 50000000,
  parameter int unsigned SAMPLE_RATE  = 48000,
  parameter int unsigned R            = 10000,
  parameter int unsigned C_16_SHIFTED = 6554
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_clk_en,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        overrun
);

  localparam logic [63:0] RC16      = 64'(R) * 64'(C_16_SHIFTED);
  localparam logic [63:0] DT16      = (64'd1000000 << 16) / 64'(SAMPLE_RATE);
  localparam logic [63:0] ALPHA_RAW = (DT16 << 16) / (RC16 + DT16);
  localparam logic [15:0] ALPHA     = (ALPHA_RAW > 64'd65535) ? 16'hFFFF : ALPHA_RAW[15:0];

  // One update occupies 18 clocks, so strobes must be at least that far apart.
  if (CLOCK_RATE / SAMPLE_RATE < 18) begin : g_rate_check
    $error("rc_lowpass_filter_serial: CLOCK_RATE/SAMPLE_RATE must be at least 18");
  end

  typedef enum logic [1:0] {IDLE, MUL, UPDATE} state_e;

  state_e             state_q, state_d;
  logic signed [16:0] diff_q, diff_d;
  logic signed [32:0] acc_q, acc_d;
  logic        [3:0]  count_q, count_d;
  logic        [15:0] y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  logic signed [32:0] diff_ext;
  logic signed [32:0] partial;
  logic signed [32:0] sum;

  function automatic logic [15:0] sat_u16(input logic signed [32:0] v);
    if (v < 33'sd0)     return 16'd0;
    if (v > 33'sd65535) return 16'hFFFF;
    return v[15:0];
  endfunction

  assign diff_ext = diff_q;
  assign partial  = diff_ext <<< count_q;
  // Arithmetic shift floors toward -inf, so a falling input always makes progress.
  assign sum      = $signed({17'd0, y_q}) + (acc_q >>> 16);

  always_comb begin
    state_d     = state_q;
    diff_d      = diff_q;
    acc_d       = acc_q;
    count_d     = count_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    overrun_d   = audio_clk_en && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          diff_d  = $signed({1'b0, in}) - $signed({1'b0, y_q});
          acc_d   = '0;
          count_d = 4'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (ALPHA[count_q]) acc_d = acc_q + partial;
        count_d = count_q + 4'd1;
        if (count_q == 4'd15) state_d = UPDATE;
      end
      UPDATE: begin
        y_d         = sat_u16(sum);
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      diff_q      <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      diff_q      <= diff_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = y_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rc_lowpass_filter_serial.sv
// Bench for rc_lowpass_filter_serial: default-coefficient and R=0 instances share
// stimulus and are checked every clock against a sample-level reference model.
module tb_rc_lowpass_filter_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] in_s;
  logic [15:0] out, out_r0;
  logic        out_valid, out_valid_r0;
  logic        overrun, overrun_r0;

  int n_checks = 0;
  int n_err    = 0;

  longint alpha_def, alpha_r0;
  int     y_def, y_r0, pend_def, pend_r0, busy;
  logic   exp_valid, exp_ovr;

  always #5 clk = ~clk;

  rc_lowpass_filter_serial dut (
    .clk(clk), .reset(rst), .audio_clk_en(en), .in(in_s),
    .out(out), .out_valid(out_valid), .overrun(overrun)
  );

  rc_lowpass_filter_serial #(.R(0)) dut_r0 (
    .clk(clk), .reset(rst), .audio_clk_en(en), .in(in_s),
    .out(out_r0), .out_valid(out_valid_r0), .overrun(overrun_r0)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint calc_alpha(input longint r, input longint c, input longint sr);
    longint rc, dt, a;
    rc = r * c;
    dt = (64'd1000000 << 16) / sr;
    a  = (dt << 16) / (rc + dt);
    return (a > 65535) ? 65535 : a;
  endfunction

  // y + floor(alpha*(x-y)/65536), clamped to the 16-bit unsigned range
  function automatic int ref_step(input int y, input int x, input longint a);
    longint p, q, s;
    p = longint'(x - y) * a;
    q = (p >= 0) ? p / 65536 : -((-p + 65535) / 65536);
    s = y + q;
    if (s < 0) s = 0;
    if (s > 65535) s = 65535;
    return int'(s);
  endfunction

  task automatic tick(input logic r, input logic e, input logic [15:0] x);
    rst = r; en = e; in_s = x;
    @(posedge clk);
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    if (r) begin
      busy = 0; y_def = 0; y_r0 = 0;
    end else if (busy > 0) begin
      exp_ovr = e;
      busy--;
      if (busy == 0) begin
        y_def = pend_def; y_r0 = pend_r0; exp_valid = 1'b1;
      end
    end else if (e) begin
      pend_def = ref_step(y_def, int'(x), alpha_def);
      pend_r0  = ref_step(y_r0, int'(x), alpha_r0);
      busy     = 17;
    end
    #1;
    check_val("valid", 32'(out_valid), 32'(exp_valid));
    check_val("overrun", 32'(overrun), 32'(exp_ovr));
    check_val("out", 32'(out), y_def);
    check_val("r0_valid", 32'(out_valid_r0), 32'(exp_valid));
    check_val("r0_out", 32'(out_r0), y_r0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, 1'b0, 16'($urandom));
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check_val("valid_seen", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int lat, prev, nvalid;
    alpha_def = calc_alpha(10000, 6554, 48000);
    alpha_r0  = calc_alpha(0, 6554, 48000);
    busy = 0; y_def = 0; y_r0 = 0; pend_def = 0; pend_r0 = 0;
    rst = 1'b1; en = 1'b0; in_s = '0;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom % 2), 16'($urandom));
    check_val("reset_out", 32'(out), 32'd0);

    // single step and second step from zero
    tick(1'b0, 1'b1, 16'hFFFF);
    wait_valid(lat);
    check_val("step1_latency", lat, 17);
    check_val("step1_out", 32'(out), 32'd1336);
    check_val("r0_step_out", 32'(out_r0), 32'd65534);
    tick(1'b0, 1'b1, 16'hFFFF);
    wait_valid(lat);
    check_val("step2_latency", lat, 17);
    check_val("step2_out", 32'(out), ref_step(1336, 65535, alpha_def));
    tick(1'b0, 1'b1, 16'h0000);
    wait_valid(lat);
    check_val("r0_fall_out", 32'(out_r0), 32'd0);

    // settle upward then downward
    tick(1'b1, 1'b0, 16'h0);
    prev = 0;
    for (int i = 0; i < 700; i++) begin
      tick(1'b0, 1'b1, 16'hFFFF);
      wait_valid(lat);
      check_val("rise_monotonic", 32'(out >= 16'(prev)), 32'd1);
      prev = int'(out);
    end
    check_val("rise_settled", 32'(out >= 16'd65486), 32'd1);
    for (int i = 0; i < 700; i++) begin
      tick(1'b0, 1'b1, 16'h0000);
      wait_valid(lat);
      check_val("fall_monotonic", 32'(out <= 16'(prev)), 32'd1);
      prev = int'(out);
    end
    check_val("fall_settled", 32'(out), 32'd0);

    // overrun: second strobe five clocks after the first
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'h1234);
    check_val("ovr_pulse", 32'(overrun), 32'd1);
    tick(1'b0, 1'b0, 16'h0);
    check_val("ovr_single_cycle", 32'(overrun), 32'd0);
    wait_valid(lat);
    check_val("ovr_latency", lat, 11);
    check_val("ovr_out", 32'(out), 32'd1336);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      nvalid += int'(out_valid);
    end
    check_val("ovr_no_second_valid", nvalid, 0);

    // reset in the middle of an update
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'hFFFF);
    tick(1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 16'hFFFF);
      nvalid += int'(out_valid);
    end
    check_val("abort_no_valid", nvalid, 0);
    check_val("abort_out", 32'(out), 32'd0);
    tick(1'b0, 1'b1, 16'hFFFF);
    wait_valid(lat);
    check_val("after_abort_latency", lat, 17);
    check_val("after_abort_out", 32'(out), 32'd1336);

    // random strobes and samples
    tick(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] x;
      case ($urandom % 4)
        0: x = 16'h0000;
        1: x = 16'hFFFF;
        default: x = 16'($urandom);
      endcase
      tick(($urandom % 50) == 0, ($urandom % 3) == 0, x);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
